// File: rtl/tri_bus_arb_pkg.sv
// Shared types and widths for the tri-state bus arbiter and its round-robin picker.
package tri_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam int unsigned TURN_W  = 2;
    localparam int unsigned OWNER_W = 3;

    // Index width for n requesters, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or above ptr, with wrap.
module rr_pick
    import tri_bus_arb_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] winner
);

    localparam int unsigned    SUM_W = IDX_W + 1;
    localparam logic [SUM_W-1:0] N_V = SUM_W'(N);

    logic [2*N-1:0]   doubled;
    logic [N-1:0]     rotated;
    logic [IDX_W-1:0] offset;
    logic [SUM_W-1:0] sum;

    // Rotate so that ptr lands on bit 0.
    assign doubled = {eligible, eligible} >> ptr;
    assign rotated = doubled[N-1:0];

    // Priority-encode the lowest set bit of the rotated vector.
    always_comb begin
        offset = '0;
        found  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IDX_W'(i);
                found  = 1'b1;
            end
        end
    end

    // Un-rotate: add ptr back modulo N.
    assign sum    = {1'b0, ptr} + {1'b0, offset};
    assign winner = (sum >= N_V) ? IDX_W'(sum - N_V) : sum[IDX_W-1:0];

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus with turnaround gap and hold-time limit.
module tri_bus_arbiter
    import tri_bus_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   din,
    output logic [N_REQ-1:0]         gnt,
    output tri   [WIDTH-1:0]         bus,
    output logic                     busy,
    output logic [OWNER_W-1:0]       owner,
    output logic                     timeout
);

    localparam int unsigned IDX_W  = idx_w(N_REQ);
    localparam int unsigned HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'((TURN_CYC == 0) ? 0 : TURN_CYC - 1);
    localparam state_t            REL_STATE = (TURN_CYC == 0) ? IDLE : TURN;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  owner_idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TURN_W-1:0] turn_cnt;
    logic [N_REQ-1:0]  lockout;
    logic [N_REQ-1:0]  eligible;
    logic              found;
    logic [IDX_W-1:0]  winner;

    assign eligible = req & ~lockout;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .found    (found),
        .winner   (winner)
    );

    assign busy  = |gnt;
    assign owner = OWNER_W'(owner_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            owner_idx <= '0;
            timeout   <= 1'b0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            turn_cnt  <= '0;
            lockout   <= '0;
        end else begin
            timeout <= 1'b0;
            // A requester that lets go of req is forgiven for a past timeout.
            lockout <= lockout & req;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt       <= N_REQ'(1) << winner;
                        owner_idx <= winner;
                        rr_ptr    <= (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[owner_idx]) begin
                        gnt      <= '0;
                        turn_cnt <= '0;
                        state    <= REL_STATE;
                    end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
                        gnt      <= '0;
                        timeout  <= 1'b1;
                        lockout  <= (lockout & req) | (N_REQ'(1) << owner_idx);
                        turn_cnt <= '0;
                        state    <= REL_STATE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        state <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt + TURN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One conditional driver per requester; gnt is one-hot so at most one is active.
    for (genvar i = 0; i < N_REQ; i++) begin : g_drv
        assign bus = gnt[i] ? din[i*WIDTH +: WIDTH] : 'z;
    end

`ifndef SYNTHESIS
    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
`endif

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: vector table plus scoreboarded multi-cycle scenarios on two configurations.
module tb_tri_bus_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [2:0] owner;
        logic       to;
    } obs_t;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [2:0] owner;
    } vec_t;

    typedef struct {
        int         st;
        int         owner;
        int         ptr;
        int         hold;
        int         turn;
        logic [3:0] lock;
        logic [3:0] gnt;
        logic       to;
    } model_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [3:0]  req_a, req_b;
    logic [31:0] din_a, din_b;
    logic [3:0]  gnt_a, gnt_b;
    wire  [7:0]  bus_a, bus_b;
    logic        busy_a, busy_b;
    logic [2:0]  owner_a, owner_b;
    logic        to_a, to_b;

    tri_bus_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(16), .TURN_CYC(1)) dut_a (
        .clk(clk), .rst_n(rst_a), .req(req_a), .din(din_a), .gnt(gnt_a),
        .bus(bus_a), .busy(busy_a), .owner(owner_a), .timeout(to_a)
    );

    tri_bus_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(0), .TURN_CYC(0)) dut_b (
        .clk(clk), .rst_n(rst_b), .req(req_b), .din(din_b), .gnt(gnt_b),
        .bus(bus_b), .busy(busy_b), .owner(owner_b), .timeout(to_b)
    );

    int     checks = 0;
    int     errors = 0;
    model_t ma, mb;
    obs_t   qa[$];
    obs_t   qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [3:0] g);
        int r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    // Reference behaviour: 0=IDLE, 1=GRANT, 2=TURN.
    function automatic model_t mstep(input model_t m, input logic [3:0] r,
                                     input int max_hold, input int turn_cyc);
        model_t n = m;
        n.to   = 1'b0;
        n.lock = m.lock & r;
        case (m.st)
            0: begin
                for (int k = 0; k < 4; k++) begin
                    int idx = (m.ptr + k) % 4;
                    if (n.st == 0 && r[idx] && !m.lock[idx]) begin
                        n.st    = 1;
                        n.gnt   = 4'(1) << idx;
                        n.owner = idx;
                        n.ptr   = (idx + 1) % 4;
                        n.hold  = 0;
                    end
                end
            end
            1: begin
                if (!r[m.owner]) begin
                    n.gnt  = 4'b0;
                    n.st   = (turn_cyc == 0) ? 0 : 2;
                    n.turn = 0;
                end else if (max_hold != 0 && m.hold == max_hold - 1) begin
                    n.gnt           = 4'b0;
                    n.to            = 1'b1;
                    n.lock[m.owner] = 1'b1;
                    n.st            = (turn_cyc == 0) ? 0 : 2;
                    n.turn          = 0;
                end else begin
                    n.hold = m.hold + 1;
                end
            end
            default: begin
                if (m.turn == turn_cyc - 1) n.st = 0;
                else n.turn = m.turn + 1;
            end
        endcase
        return n;
    endfunction

    task automatic check_obs(input string tag, input obs_t e, input logic [3:0] g, input logic b,
                             input logic [2:0] o, input logic t, input logic [7:0] bv,
                             input logic [31:0] d);
        chk({tag, " gnt"}, 32'(g), 32'(e.gnt));
        chk({tag, " busy"}, 32'(b), 32'(|e.gnt));
        chk({tag, " owner"}, 32'(o), 32'(e.owner));
        chk({tag, " timeout"}, 32'(t), 32'(e.to));
        chk({tag, " onehot"}, 32'($onehot0(g)), 32'd1);
        for (int i = 0; i < 4; i++)
            if (e.gnt[i]) chk({tag, " bus"}, 32'(bv), 32'(d[i*8 +: 8]));
    endtask

    // One clock: push model predictions for both DUTs, then pop and compare after the edge.
    task automatic cyc();
        obs_t ea, eb;
        ma = mstep(ma, req_a, 16, 1);
        mb = mstep(mb, req_b, 0, 0);
        qa.push_back({ma.gnt, 3'(ma.owner), ma.to});
        qb.push_back({mb.gnt, 3'(mb.owner), mb.to});
        @(posedge clk);
        #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        check_obs("a", ea, gnt_a, busy_a, owner_a, to_a, bus_a, din_a);
        check_obs("b", eb, gnt_b, busy_b, owner_b, to_b, bus_b, din_b);
    endtask

    task automatic do_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        req_a = 4'b0;
        req_b = 4'b0;
        ma = '{0, 0, 0, 0, 0, 4'b0, 4'b0, 1'b0};
        mb = '{0, 0, 0, 0, 0, 4'b0, 4'b0, 1'b0};
        qa.delete();
        qb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [19];
        obs_t       e;
        logic [3:0] prev, r;
        int         order[$];
        int         gaps[$];
        int         exp_order[5];
        int         low, cnt0, tos;
        bit         seen, seen2, done2, rel;

        din_a = 32'h5AC3_A511;
        din_b = 32'h0000_7E81;
        exp_order = '{0, 1, 2, 3, 0};

        tbl[0]  = '{4'b0010, 4'b0010, 3'd1};
        tbl[1]  = '{4'b0010, 4'b0010, 3'd1};
        tbl[2]  = '{4'b0010, 4'b0010, 3'd1};
        tbl[3]  = '{4'b0000, 4'b0000, 3'd1};
        tbl[4]  = '{4'b0000, 4'b0000, 3'd1};
        tbl[5]  = '{4'b0000, 4'b0000, 3'd1};
        tbl[6]  = '{4'b1001, 4'b1000, 3'd3};
        tbl[7]  = '{4'b1001, 4'b1000, 3'd3};
        tbl[8]  = '{4'b0001, 4'b0000, 3'd3};
        tbl[9]  = '{4'b0001, 4'b0000, 3'd3};
        tbl[10] = '{4'b0001, 4'b0001, 3'd0};
        tbl[11] = '{4'b0000, 4'b0000, 3'd0};
        tbl[12] = '{4'b0110, 4'b0000, 3'd0};
        tbl[13] = '{4'b0110, 4'b0010, 3'd1};
        tbl[14] = '{4'b0100, 4'b0000, 3'd1};
        tbl[15] = '{4'b0100, 4'b0000, 3'd1};
        tbl[16] = '{4'b0100, 4'b0100, 3'd2};
        tbl[17] = '{4'b0000, 4'b0000, 3'd2};
        tbl[18] = '{4'b0000, 4'b0000, 3'd2};

        // Reset state
        do_reset();
        check_obs("reset a", obs_t'(8'h00), gnt_a, busy_a, owner_a, to_a, bus_a, din_a);
        check_obs("reset b", obs_t'(8'h00), gnt_b, busy_b, owner_b, to_b, bus_b, din_b);

        // Vector table on configuration A
        for (int i = 0; i < 19; i++) begin
            req_a = tbl[i].req;
            @(posedge clk);
            #1;
            e = {tbl[i].gnt, tbl[i].owner, 1'b0};
            check_obs("vec", e, gnt_a, busy_a, owner_a, to_a, bus_a, din_a);
        end

        // Round robin: each owner drops req two cycles after its grant
        do_reset();
        prev = 4'b0;
        low  = 0;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            r = 4'b1111;
            if (ma.st == 1 && ma.hold == 1) r[ma.owner] = 1'b0;
            req_a = r;
            cyc();
            if (gnt_a != 4'b0 && prev == 4'b0) begin
                order.push_back(idx_of(gnt_a));
                if (order.size() > 1) gaps.push_back(low);
                low = 0;
            end
            if (gnt_a == 4'b0) low++;
            prev = gnt_a;
        end
        chk("rr grants", 32'(order.size()), 32'd5);
        for (int i = 0; i < order.size() && i < 5; i++) chk("rr order", 32'(order[i]), 32'(exp_order[i]));
        foreach (gaps[i]) chk("rr gap", 32'(gaps[i]), 32'd2);

        // Timeout: req0 held forever, req2 also requesting
        do_reset();
        cnt0 = 0; tos = 0; seen2 = 0; done2 = 0;
        for (int c = 0; c < 40; c++) begin
            r = 4'b0101;
            if (done2) r[2] = 1'b0;
            if (ma.st == 1 && ma.owner == 2 && ma.hold == 2) begin
                r[2] = 1'b0;
                done2 = 1;
            end
            req_a = r;
            cyc();
            if (gnt_a[0]) cnt0++;
            if (gnt_a[2]) seen2 = 1;
            if (to_a) tos++;
        end
        chk("to gnt0 cycles", 32'(cnt0), 32'd16);
        chk("to pulses", 32'(tos), 32'd1);
        chk("to gnt2 next", 32'(seen2), 32'd1);
        req_a = 4'b0000;
        cyc();
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            req_a = 4'b0001;
            cyc();
            if (gnt_a[0]) seen = 1;
        end
        chk("to regrant after drop", 32'(seen), 32'd1);

        // req0 dropped exactly when the hold limit is reached
        do_reset();
        cnt0 = 0; tos = 0; seen = 0; rel = 0;
        for (int c = 0; c < 22; c++) begin
            r = 4'b0001;
            if (ma.st == 1 && ma.hold == 15) r = 4'b0000;
            req_a = r;
            cyc();
            if (to_a) tos++;
            if (gnt_a[0] && !rel) cnt0++;
            if (!gnt_a[0] && cnt0 > 0) rel = 1;
            if (rel && gnt_a[0]) seen = 1;
        end
        chk("drop len", 32'(cnt0), 32'd16);
        chk("drop timeout", 32'(tos), 32'd0);
        chk("drop no lockout", 32'(seen), 32'd1);

        // Async reset between edges while gnt=0100
        do_reset();
        req_a = 4'b0100;
        cyc();
        cyc();
        chk("ar pre gnt", 32'(gnt_a), 32'h4);
        #3;
        rst_a = 1'b0;
        #1;
        chk("ar gnt", 32'(gnt_a), 32'h0);
        chk("ar busy", 32'(busy_a), 32'h0);
        chk("ar owner", 32'(owner_a), 32'h0);
        ma = '{0, 0, 0, 0, 0, 4'b0, 4'b0, 1'b0};
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        req_a = 4'b0110;
        cyc();
        chk("ar first grant", 32'(gnt_a), 32'h2);

        // Configuration B: unlimited hold, no turnaround
        do_reset();
        cnt0 = 0; tos = 0;
        for (int c = 0; c < 100; c++) begin
            req_b = 4'b0011;
            cyc();
            if (gnt_b == 4'b0001) cnt0++;
            if (to_b) tos++;
        end
        chk("b hold cycles", 32'(cnt0), 32'd100);
        prev = gnt_b;
        low  = 0;
        order.delete();
        gaps.delete();
        for (int c = 0; c < 60; c++) begin
            r = 4'b0011;
            if (mb.st == 1 && mb.hold >= 3) r[mb.owner] = 1'b0;
            req_b = r;
            cyc();
            if (to_b) tos++;
            if (gnt_b != 4'b0 && prev == 4'b0) begin
                order.push_back(idx_of(gnt_b));
                gaps.push_back(low);
                low = 0;
            end
            if (gnt_b == 4'b0) low++;
            prev = gnt_b;
        end
        chk("b timeout", 32'(tos), 32'd0);
        chk("b grants", 32'(order.size() >= 10), 32'd1);
        if (order.size() > 0) chk("b first alt", 32'(order[0]), 32'd1);
        for (int i = 1; i < order.size(); i++) chk("b alternate", 32'(order[i]), 32'(1 - order[i-1]));
        foreach (gaps[i]) chk("b gap", 32'(gaps[i]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
